// File: rtl/fxp_addsub_acc.sv
// Two-stage pipelined fixed-point add/subtract/accumulate unit with
// saturate-or-wrap overflow handling and valid/ready flow control.
module fxp_addsub_acc #(
    parameter int BIT_WIDTH = 16,
    parameter int SATURATE  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] y,
    output logic                 ovf,
    output logic                 ovf_sticky,
    input  logic                 clr_sticky
);
    localparam int W = BIT_WIDTH;
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic         en;
    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [1:0]   s1_op;
    logic [W-1:0] acc;
    logic [W:0]   r;
    logic         r_ovf;
    logic [W-1:0] r_y;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Stage 2 arithmetic; one extra bit holds the exact result of two W-bit operands.
    always_comb begin
        r = '0;
        case (s1_op)
            2'b00:   r = {s1_a[W-1], s1_a} + {s1_b[W-1], s1_b};
            2'b01:   r = {s1_a[W-1], s1_a} - {s1_b[W-1], s1_b};
            2'b10:   r = {acc[W-1], acc} + {s1_a[W-1], s1_a};
            default: r = {s1_a[W-1], s1_a};
        endcase
    end

    always_comb begin
        r_ovf = (r[W] != r[W-1]);
        r_y   = r[W-1:0];
        if (r_ovf && (SATURATE != 0)) begin
            r_y = r[W] ? MIN_VAL : MAX_VAL;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= 2'b00;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y   <= r_y;
                ovf <= r_ovf;
                if (s1_op[1]) begin
                    acc <= r_y;
                end
            end else begin
                ovf <= 1'b0;
            end
        end
    end

    // Clear works even while stalled; a new overflow in the same cycle wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (ovf_sticky && !clr_sticky) || (en && s1_valid && r_ovf);
        end
    end

endmodule

// File: tb/tb_fxp_addsub_acc.sv
// Scoreboard bench: a saturating and a wrapping instance share one stimulus
// stream; expected results are queued on acceptance and popped by a monitor.
module tb_fxp_addsub_acc;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [1:0]  op = 2'b00;
    logic        out_ready = 1'b1;
    logic        clr_sticky = 1'b0;

    logic        rdy_s, ov_s, ovf_s, st_s;
    logic        rdy_w, ov_w, ovf_w, st_w;
    logic [15:0] y_s, y_w;

    fxp_addsub_acc #(.BIT_WIDTH(16), .SATURATE(1)) u_sat (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy_s),
        .a(a), .b(b), .op(op), .out_valid(ov_s), .out_ready(out_ready),
        .y(y_s), .ovf(ovf_s), .ovf_sticky(st_s), .clr_sticky(clr_sticky));

    fxp_addsub_acc #(.BIT_WIDTH(16), .SATURATE(0)) u_wrap (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy_w),
        .a(a), .b(b), .op(op), .out_valid(ov_w), .out_ready(out_ready),
        .y(y_w), .ovf(ovf_w), .ovf_sticky(st_w), .clr_sticky(clr_sticky));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] ys;
        logic        os;
        logic [15:0] yw;
        logic        ow;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int stall_mode = 0;   // 0: always ready, 1: random, 2: never ready
    logic [15:0] macc_s = '0;
    logic [15:0] macc_w = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [1:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                                  input logic [15:0] macc, input bit sat,
                                  output logic [15:0] my, output logic mo);
        int r;
        case (mop)
            2'b00:   r = int'($signed(ma)) + int'($signed(mb));
            2'b01:   r = int'($signed(ma)) - int'($signed(mb));
            2'b10:   r = int'($signed(macc)) + int'($signed(ma));
            default: r = int'($signed(ma));
        endcase
        mo = (r > 32767) || (r < -32768);
        my = r[15:0];
        if (mo && sat) my = (r > 0) ? 16'h7FFF : 16'h8000;
    endfunction

    // hand=1 pushes the hand-computed values; hand=0 uses the reference model.
    task automatic send(input logic [1:0] vop, input logic [15:0] va, input logic [15:0] vb,
                        input bit hand, input logic [15:0] hys, input logic hos,
                        input logic [15:0] hyw, input logic how);
        exp_t e;
        logic [15:0] ys, yw;
        logic os, ow;
        bit ok = 0;
        op = vop; a = va; b = vb; in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (rdy_s) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready stuck at 0 expected 1");
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        model(vop, va, vb, macc_s, 1'b1, ys, os);
        model(vop, va, vb, macc_w, 1'b0, yw, ow);
        if (vop[1]) begin macc_s = ys; macc_w = yw; end
        if (hand) begin e.ys = hys; e.os = hos; e.yw = hyw; e.ow = how; end
        else      begin e.ys = ys;  e.os = os;  e.yw = yw;  e.ow = ow;  end
        if (ok) sb.push_back(e);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge CLK); #1;
            if (sb.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
        end
    endtask

    always begin
        @(posedge CLK); #1;
        if (stall_mode == 1)      out_ready = ($urandom_range(0, 2) != 0);
        else if (stall_mode == 2) out_ready = 1'b0;
        else                      out_ready = 1'b1;
    end

    // Monitor: samples on the falling edge, away from the active edge.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_ys = '0, prev_yw = '0;
    always begin
        exp_t e;
        @(negedge CLK);
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", {31'd0, rdy_s}, {31'd0, !(ov_s && !out_ready)});
            if (prev_stall) begin
                chk("stall_hold_sat",  {16'd0, y_s}, {16'd0, prev_ys});
                chk("stall_hold_wrap", {16'd0, y_w}, {16'd0, prev_yw});
                chk("stall_valid",     {31'd0, ov_s}, 32'd1);
            end
            if (ov_s && out_ready) begin
                chk("valid_pair", {31'd0, ov_w}, {31'd0, ov_s});
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL extra_output: y=0x%0h with no beat outstanding", y_s);
                end else begin
                    e = sb.pop_front();
                    chk("y_sat",    {16'd0, y_s},   {16'd0, e.ys});
                    chk("ovf_sat",  {31'd0, ovf_s}, {31'd0, e.os});
                    chk("y_wrap",   {16'd0, y_w},   {16'd0, e.yw});
                    chk("ovf_wrap", {31'd0, ovf_w}, {31'd0, e.ow});
                end
            end
            prev_stall = ov_s && !out_ready;
            prev_ys = y_s;
            prev_yw = y_w;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [15:0] ra, rb;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", {31'd0, ov_s}, 32'd0);
        chk("rst_y", {16'd0, y_s}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_s}, 32'd0);
        chk("rst_sticky", {31'd0, st_s}, 32'd0);
        chk("rst_in_ready", {31'd0, rdy_s}, 32'd1);
        RST = 1'b0;
        @(posedge CLK); #1;

        send(2'b00, 16'h1234, 16'h0101, 1, 16'h1335, 0, 16'h1335, 0);
        drain();
        chk("sticky_clean", {31'd0, st_s}, 32'd0);

        send(2'b00, 16'h7FFF, 16'h0001, 1, 16'h7FFF, 1, 16'h8000, 1);
        drain();
        chk("sticky_set_sat", {31'd0, st_s}, 32'd1);
        chk("sticky_set_wrap", {31'd0, st_w}, 32'd1);

        // Clear held across acceptance and the overflowing stage-2 edge.
        clr_sticky = 1'b1;
        send(2'b01, 16'h8000, 16'h0001, 1, 16'h8000, 1, 16'h7FFF, 1);
        chk("sticky_cleared", {31'd0, st_s}, 32'd0);
        @(posedge CLK); #1;
        clr_sticky = 1'b0;
        chk("sticky_clr_and_set", {31'd0, st_s}, 32'd1);
        drain();

        send(2'b01, 16'h0000, 16'h8000, 1, 16'h7FFF, 1, 16'h8000, 1);

        send(2'b11, 16'd5, 16'h0000, 1, 16'd5, 0, 16'd5, 0);
        send(2'b10, 16'd3, 16'h0000, 1, 16'd8, 0, 16'd8, 0);
        send(2'b10, 16'hFFF6, 16'h0000, 1, 16'hFFFE, 0, 16'hFFFE, 0);
        send(2'b00, 16'd1, 16'd1, 1, 16'd2, 0, 16'd2, 0);
        send(2'b10, 16'd2, 16'h0000, 1, 16'd0, 0, 16'd0, 0);
        send(2'b10, 16'd0, 16'h0000, 1, 16'd0, 0, 16'd0, 0);
        drain();

        stall_mode = 1;
        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(rop, ra, rb, 0, 16'h0, 0, 16'h0, 0);
        end
        drain();
        stall_mode = 0;

        send(2'b11, 16'h0100, 16'h0000, 1, 16'h0100, 0, 16'h0100, 0);
        drain();
        stall_mode = 2;
        @(posedge CLK); #1;
        op = 2'b10; a = 16'h0007; in_valid = 1'b1;
        @(posedge CLK); #1;
        a = 16'h0009;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("full_valid", {31'd0, ov_s}, 32'd1);
        chk("full_in_ready", {31'd0, rdy_s}, 32'd0);
        chk("pre_rst_sticky", {31'd0, st_s}, 32'd1);
        RST = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, ov_s}, 32'd0);
        chk("async_rst_sticky", {31'd0, st_s}, 32'd0);
        chk("async_rst_y", {16'd0, y_s}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        sb.delete();
        macc_s = '0;
        macc_w = '0;
        stall_mode = 0;
        @(posedge CLK); #1;
        chk("post_rst_valid", {31'd0, ov_s}, 32'd0);
        send(2'b10, 16'h0001, 16'h0000, 1, 16'h0001, 0, 16'h0001, 0);
        drain();
        repeat (3) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
